// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin job controller sharing one counter4bit between two requesters
// Outputs are flopped from the next-state decode, so they are a pure function of the registered state.
module counter_arbiter #(
  parameter int WIDTH   = 4,
  parameter int SAT_MAX = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [1:0]       sat,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_rst,
  output logic             cnt_sat,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] SAT_LIM = WIDTH'(SAT_MAX);

  state_t           state, state_nx;
  logic             owner, owner_nx;
  logic             mode, mode_nx;
  logic             rr, rr_nx;
  logic [WIDTH-1:0] target, target_nx;

  logic             win;
  logic [WIDTH-1:0] len_sel;

  logic             cnt_rst_nx, cnt_sat_nx, busy_nx;
  logic [1:0]       gnt_nx, done_nx;

  // rr only breaks ties; a lone requester always wins
  always_comb begin
    win     = (req == 2'b11) ? rr : req[1];
    len_sel = win ? len1 : len0;
  end

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    mode_nx   = mode;
    rr_nx     = rr;
    target_nx = target;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nx  = win;
          mode_nx   = sat[win];
          target_nx = (sat[win] && (len_sel > SAT_LIM)) ? SAT_LIM : len_sel;
          state_nx  = RUN;
        end
      end
      RUN: begin
        // an owner dropping req is an abort and wins over a same-cycle match
        if (!req[owner]) begin
          rr_nx    = ~owner;
          state_nx = IDLE;
        end else if (cnt_val == target) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        rr_nx    = ~owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_rst_nx = 1'b1;
    cnt_sat_nx = 1'b0;
    gnt_nx     = 2'b00;
    done_nx    = 2'b00;
    busy_nx    = 1'b0;
    case (state_nx)
      RUN: begin
        cnt_rst_nx = 1'b0;
        cnt_sat_nx = mode_nx;
        gnt_nx     = owner_nx ? 2'b10 : 2'b01;
        busy_nx    = 1'b1;
      end
      DONE: begin
        gnt_nx  = owner_nx ? 2'b10 : 2'b01;
        done_nx = owner_nx ? 2'b10 : 2'b01;
        busy_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      mode    <= 1'b0;
      rr      <= 1'b0;
      target  <= '0;
      cnt_rst <= 1'b1;
      cnt_sat <= 1'b0;
      gnt     <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      mode    <= mode_nx;
      rr      <= rr_nx;
      target  <= target_nx;
      cnt_rst <= cnt_rst_nx;
      cnt_sat <= cnt_sat_nx;
      gnt     <= gnt_nx;
      done    <= done_nx;
      busy    <= busy_nx;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed bench for counter_arbiter with a behavioural counter4bit
module tb_counter_arbiter;

  localparam int SAT = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] sat;
  logic [3:0] cnt_val = 4'd0;
  logic       cnt_rst, cnt_sat, busy;
  logic [1:0] gnt, done;

  int vectors = 0;
  int miscompares = 0;

  counter_arbiter #(.WIDTH(4), .SAT_MAX(SAT)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1), .sat(sat),
    .cnt_val(cnt_val), .cnt_rst(cnt_rst), .cnt_sat(cnt_sat), .gnt(gnt),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // counter4bit: sync clear, saturate at SAT when satEn, else wrap
  always @(posedge clk) begin
    if (cnt_rst) cnt_val <= 4'd0;
    else if (cnt_sat && cnt_val == 4'(SAT)) cnt_val <= cnt_val;
    else cnt_val <= cnt_val + 4'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rst"}, 32'(cnt_rst), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Call in the IDLE cycle before the grant edge; returns in the DONE cycle.
  task automatic job(input string tag, input int own, input int t, input bit sm, input int dval);
    logic [1:0] g;
    g = (own == 1) ? 2'b10 : 2'b01;
    tick;
    chk({tag, "_G_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_G_busy"}, 32'(busy), 32'd1);
    chk({tag, "_G_rst"}, 32'(cnt_rst), 32'd0);
    chk({tag, "_G_sat"}, 32'(cnt_sat), 32'(sm));
    chk({tag, "_G_cnt"}, 32'(cnt_val), 32'd0);
    chk({tag, "_G_done"}, 32'(done), 32'd0);
    for (int k = 1; k <= t; k++) begin
      tick;
      chk({tag, "_run_cnt"}, 32'(cnt_val), 32'(k));
      chk({tag, "_run_gnt"}, 32'(gnt), 32'(g));
      chk({tag, "_run_sat"}, 32'(cnt_sat), 32'(sm));
      chk({tag, "_run_done"}, 32'(done), 32'd0);
    end
    tick;
    chk({tag, "_D_done"}, 32'(done), 32'(g));
    chk({tag, "_D_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_D_rst"}, 32'(cnt_rst), 32'd1);
    chk({tag, "_D_busy"}, 32'(busy), 32'd1);
    chk({tag, "_D_cnt"}, 32'(cnt_val), 32'(dval));
  endtask

  initial begin
    reset = 1'b0;
    req   = 2'b00;
    len0  = 4'd0;
    len1  = 4'd0;
    sat   = 2'b00;
    tick;
    tick;
    chk_idle("rst");
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    reset = 1'b1;
    tick;

    // lone req0, wrap, target 5
    req = 2'b01; len0 = 4'd5;
    job("t5", 0, 5, 1'b0, 6);
    req = 2'b00;
    tick;
    chk_idle("t5_idle");

    // reset mid-RUN (rr was left at 1)
    req = 2'b01; len0 = 4'd9;
    tick;
    for (int k = 1; k <= 4; k++) tick;
    chk("mr_cnt", 32'(cnt_val), 32'd4);
    reset = 1'b0;
    #1;
    chk_idle("mr");
    chk("mr_sat", 32'(cnt_sat), 32'd0);
    req = 2'b00;
    tick;
    chk("mr_held_done", 32'(done), 32'd0);
    #1;
    reset = 1'b1;

    // both requesting continuously: rr=0 after reset so order is 0,1,0,1
    req = 2'b11; len0 = 4'd2; len1 = 4'd3;
    job("rr_a", 0, 2, 1'b0, 3);
    tick;
    chk_idle("rr_a_idle");
    job("rr_b", 1, 3, 1'b0, 4);
    tick;
    chk_idle("rr_b_idle");
    job("rr_c", 0, 2, 1'b0, 3);
    tick;
    chk_idle("rr_c_idle");
    job("rr_d", 1, 3, 1'b0, 4);
    req = 2'b00;
    tick;
    chk_idle("rr_d_idle");

    // saturating req1, len 14 clamps to 11
    req = 2'b10; len1 = 4'd14; sat = 2'b10;
    job("clamp", 1, 11, 1'b1, 11);
    req = 2'b00; sat = 2'b00;
    tick;
    chk_idle("clamp_idle");

    // abort: owner 0 drops at cnt_val=3; rr must move to 1 so req1 wins the tie
    req = 2'b01; len0 = 4'd10; len1 = 4'd1;
    tick;
    req = 2'b11;
    for (int k = 1; k <= 3; k++) tick;
    chk("ab_cnt", 32'(cnt_val), 32'd3);
    chk("ab_gnt", 32'(gnt), 32'd1);
    req = 2'b10;
    tick;
    chk_idle("ab_idle");
    req = 2'b11;
    job("ab_next", 1, 1, 1'b0, 2);
    req = 2'b00;
    tick;
    chk_idle("ab_next_idle");

    // wrap target 15, then target 0
    req = 2'b01; len0 = 4'd15;
    job("w15", 0, 15, 1'b0, 0);
    req = 2'b00;
    tick;
    chk_idle("w15_idle");
    req = 2'b01; len0 = 4'd0;
    job("z0", 0, 0, 1'b0, 1);
    req = 2'b00;
    tick;
    chk_idle("z0_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
